mux6_scan_sequencer: RTL and testbench
======================================

// Module: mux6_scan_sequencer
// PURPOSE
//  Select-stage sequencer that sits directly upstream of the 6:1 mux. It drives the mux select (sel),
//  holds each channel for DWELL cycles and then samples the mux output (mux_y) into a shadow register.
//  After the last channel it publishes all channels as a parallel result word with a one-cycle done pulse.
//  It replaces a hand-stepped select with a start/abort controlled scan, single-shot or continuous.
// PARAMETERS
//  N_CH   6  number of mux channels scanned; 2 <= N_CH <= 2**SEL_W
//  SEL_W  3  select width; matches the mux select port
//  DWELL  2  cycles each sel value is held before mux_y is sampled; DWELL >= 1
// PORTS
//  clk           in   1      single clock; all state updates on rising edge
//  rst_n         in   1      reset, asynchronous assert, active-low
//  start         in   1      begin a scan; honoured only in IDLE
//  continuous    in   1      sampled at final channel; 1 = wrap and rescan without returning to IDLE
//  abort         in   1      synchronous stop; returns to IDLE and discards the partial scan
//  mux_y         in   1      mux output for the currently driven sel
//  sel           out  SEL_W  mux select, registered
//  busy          out  1      high while in SCAN
//  done          out  1      one-cycle pulse after each completed scan
//  result        out  N_CH   result[k] = mux_y sampled while sel==k; updated only on completion
//  result_valid  out  1      set on the first completion; cleared by the next accepted start
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): state=IDLE, sel=0, dwell_cnt=0, shadow=0, result=0, busy=0,
//   done=0, result_valid=0. Reset mid-scan discards everything and no done is produced.
//  FSM states: IDLE and SCAN. done is a registered side pulse, not a separate state.
//  IDLE:
//   - sel=0, busy=0.
//   - start=1 at edge E0 -> SCAN with sel=0, dwell_cnt=0, result_valid=0.
//  SCAN, each edge:
//   - dwell_cnt < DWELL-1: dwell_cnt++.
//   - dwell_cnt == DWELL-1: shadow[sel] <= mux_y and dwell_cnt <= 0. Then:
//     - sel < N_CH-1: sel++.
//     - sel == N_CH-1: result <= {mux_y, shadow[N_CH-2:0]}, done <= 1 for one cycle,
//       result_valid <= 1. If continuous=1, sel <= 0 and stay in SCAN. Otherwise go to IDLE with sel=0.
//  Timing:
//   - Channel k is sampled at edge E0 + (k+1)*DWELL.
//   - Completion edge is E0 + N_CH*DWELL (E12 at defaults). done is high for the cycle after it.
//   - busy is high from after E0 through the completion edge. It stays high in continuous mode.
//  Latency: start to result update is N_CH*DWELL cycles.
//  Boundaries:
//   - start while busy: ignored, no restart.
//   - abort=1 in SCAN: next state IDLE, sel=0, dwell_cnt=0. result and result_valid are unchanged
//     and no done pulse occurs. abort has priority over a coincident completion.
//   - abort and start in the same IDLE cycle: abort wins and the block stays in IDLE.
//   - sel never exceeds N_CH-1. Wrap N_CH-1 -> 0 occurs only at completion in continuous mode.
//   - Clearing continuous mid-scan takes effect at that scan's completion.
//   - mux_y is treated as settled by the sampling edge, since sel has been stable for DWELL cycles.
// TESTING (defaults; bench models mux_y = I[sel] with I=6'b001111)
//  1. Single scan: start pulse at E0 -> sel steps 0,0,1,1,..,5,5; done high the cycle after E12;
//     result=6'b001111; result_valid=1; busy=0 and sel=0 after E12.
//  2. Continuous: continuous=1, start -> done pulses after E12, E24 and E36; sel wraps 5->0 with no idle
//     cycle. Change I to 6'b110000 during scan 2 -> scan 3 result=6'b110000.
//  3. Abort at sel=3 -> busy=0 and sel=0 next cycle; no done; result and result_valid keep prior values.
//  4. Async reset: drop rst_n mid-cycle while sel=4 -> all outputs 0 immediately. After release,
//     a fresh start yields a full scan.
//  5. start held high through a scan -> second scan begins on the cycle after the completion edge
//     (IDLE for 1 cycle). start pulses during SCAN have no effect.
//  6. DWELL=1, N_CH=6 -> sel changes every cycle; done high the cycle after E6; result correct.

Source files
------------

// File: rtl/mux6_scan_sequencer.sv
// mux6_scan_sequencer
//   Drives the select of an N_CH:1 mux. Each select value is held for
//   DWELL cycles, then the mux output is captured for that channel. When
//   the last channel has been captured, all channel bits are published
//   together on result, with a one-cycle done pulse. A scan is started
//   with start and stopped early with abort. In continuous mode the block
//   wraps back to channel 0 and scans again without returning to idle.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         begin a scan (honoured only when idle)
//   continuous    sampled at the final channel; 1 = rescan immediately
//   abort         synchronous stop, discards the partial scan
//   mux_y         mux output for the currently driven sel
//   sel           registered mux select
//   busy          high while scanning
//   done          one-cycle pulse after each completed scan
//   result        result[k] = mux_y captured while sel == k
//   result_valid  set on first completion, cleared by an accepted start
module mux6_scan_sequencer #(
  parameter int N_CH  = 6,
  parameter int SEL_W = 3,
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             mux_y,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [N_CH-1:0]  result,
  output logic             result_valid
);

  typedef enum logic {IDLE, SCAN} state_t;

  // A dwell counter of at least one bit keeps DWELL=1 legal.
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_CH - 1);

  state_t          state;
  logic [DW_W-1:0] dwell_cnt;
  // The last channel goes straight into result, so the shadow only needs
  // to hold channels 0..N_CH-2.
  logic [N_CH-2:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel          <= '0;
      dwell_cnt    <= '0;
      shadow       <= '0;
      result       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sel       <= '0;
          dwell_cnt <= '0;
          busy      <= 1'b0;
          // abort outranks a coincident start
          if (start && !abort) begin
            state        <= SCAN;
            busy         <= 1'b1;
            result_valid <= 1'b0;
          end
        end
        SCAN: begin
          if (abort) begin
            // abort also outranks a coincident completion
            state     <= IDLE;
            sel       <= '0;
            dwell_cnt <= '0;
            busy      <= 1'b0;
          end else if (dwell_cnt != DWELL_LAST) begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
          end else begin
            dwell_cnt <= '0;
            if (sel != SEL_LAST) begin
              shadow[sel] <= mux_y;
              sel         <= sel + SEL_W'(1);
            end else begin
              result       <= {mux_y, shadow};
              done         <= 1'b1;
              result_valid <= 1'b1;
              sel          <= '0;
              if (!continuous) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux6_scan_sequencer.sv
module tb_mux6_scan_sequencer;

  localparam int N = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, continuous, abort;
  logic [5:0] pat;

  // instance 0: DWELL=2, instance 1: DWELL=1
  logic [2:0] sel_a, sel_b;
  logic       busy_a, busy_b, done_a, done_b, rv_a, rv_b;
  logic [5:0] res_a, res_b;
  logic       y_a, y_b;

  assign y_a = pat[sel_a];
  assign y_b = pat[sel_b];

  always #5 clk = ~clk;

  mux6_scan_sequencer #(.N_CH(6), .SEL_W(3), .DWELL(2)) u_dut_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .abort(abort), .mux_y(y_a), .sel(sel_a), .busy(busy_a), .done(done_a),
    .result(res_a), .result_valid(rv_a)
  );

  mux6_scan_sequencer #(.N_CH(6), .SEL_W(3), .DWELL(1)) u_dut_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .abort(abort), .mux_y(y_b), .sel(sel_b), .busy(busy_b), .done(done_b),
    .result(res_b), .result_valid(rv_b)
  );

  int checks   = 0;
  int failures = 0;
  int n_done[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a scan is a timeline of elapsed cycles t since the
  // start edge; channel k is captured when t reaches (k+1)*dwell and the
  // scan completes when t reaches N*dwell.
  int         dw[2] = '{2, 1};
  bit         m_active[2];
  int         m_t[2];
  logic [5:0] m_cap[2];
  logic [5:0] m_res[2];
  bit         m_done[2];
  bit         m_rv[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 0; m_t[i] = 0; m_cap[i] = '0;
        m_res[i] = '0; m_done[i] = 0; m_rv[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 0;
        if (!m_active[i]) begin
          if (start && !abort) begin
            m_active[i] = 1; m_t[i] = 0; m_rv[i] = 0;
          end
        end else if (abort) begin
          m_active[i] = 0; m_t[i] = 0;
        end else begin
          m_t[i]++;
          if (m_t[i] % dw[i] == 0) begin
            m_cap[i][m_t[i] / dw[i] - 1] = pat[m_t[i] / dw[i] - 1];
            if (m_t[i] == N * dw[i]) begin
              m_res[i]  = m_cap[i];
              m_done[i] = 1;
              m_rv[i]   = 1;
              m_t[i]    = 0;
              if (!continuous) m_active[i] = 0;
            end
          end
        end
      end
    end
  end

  function automatic int exp_sel(input int i);
    return m_active[i] ? m_t[i] / dw[i] : 0;
  endfunction

  task automatic compare_all();
    check_val("d2_sel",   32'(sel_a),  32'(exp_sel(0)));
    check_val("d2_busy",  32'(busy_a), 32'(m_active[0]));
    check_val("d2_done",  32'(done_a), 32'(m_done[0]));
    check_val("d2_result",32'(res_a),  32'(m_res[0]));
    check_val("d2_rvalid",32'(rv_a),   32'(m_rv[0]));
    check_val("d1_sel",   32'(sel_b),  32'(exp_sel(1)));
    check_val("d1_busy",  32'(busy_b), 32'(m_active[1]));
    check_val("d1_done",  32'(done_b), 32'(m_done[1]));
    check_val("d1_result",32'(res_b),  32'(m_res[1]));
    check_val("d1_rvalid",32'(rv_b),   32'(m_rv[1]));
    if (done_a) n_done[0]++;
    if (done_b) n_done[1]++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    pat = 6'b001111;
    n_done[0] = 0; n_done[1] = 0;
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // single scan with the reference pattern
    @(negedge clk); start = 1'b1;
    @(negedge clk); compare_all(); start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); compare_all();
    end
    check_val("single_result_d2", 32'(res_a), 32'h0F);
    check_val("single_result_d1", 32'(res_b), 32'h0F);
    check_val("single_done_d2",   32'(n_done[0]), 32'd1);
    check_val("single_done_d1",   32'(n_done[1]), 32'd1);
    check_val("single_idle_d2",   32'({busy_a, sel_a}), 32'd0);

    // randomized phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      compare_all();
      if (cyc == 1500) begin
        // asynchronous reset in the middle of a cycle
        #2 rst_n = 1'b0;
        #1 compare_all();
        check_val("async_rst_outs", 32'({sel_a, busy_a, done_a, res_a, rv_a}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      if (cyc >= 1000 && cyc < 1200) begin
        start = 1'b1; abort = 1'b0; continuous = 1'b0;
      end else begin
        start = ($urandom_range(0, 3) == 0);
        abort = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 39) == 0) continuous = ~continuous;
      end
      if ($urandom_range(0, 29) == 0) pat = 6'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
